// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus for the hex display controller: word address,
// write/read strobes, fixed read latency of one cycle, no waitrequest.
interface hex_display_ctrl_if;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/hex_display_ctrl.sv
// Six-digit seven-segment controller with blink, scroll and per-position
// blanking, driven by a divided display tick and an Avalon-MM register file.
module hex_display_ctrl #(
  parameter int TICK_DIV = 12500000
) (
  input  logic               clk,
  input  logic               reset_n,
  hex_display_ctrl_if.slave  bus,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [15:0]   digits_lo_reg;
  logic [7:0]    digits_hi_reg;
  logic          en_reg, blink_reg, scroll_reg;
  logic [5:0]    blank_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          phase_reg, phase_next;
  logic [2:0]    offset_reg, offset_next;
  logic [31:0]   readdata_reg, rd_mux;
  logic [6:0]    hex_reg [6];
  logic [6:0]    hex_next [6];
  logic [3:0]    digit [6];

  logic wr_ctrl, tick, en_next, blink_next, scroll_next;
  logic unused_wd;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign unused_wd = &{1'b0, bus.writedata[31:16]};

  // A CTRL write landing in the tick cycle wins: phase/offset see the new bits.
  assign wr_ctrl     = bus.write && (bus.address == 3'd2);
  assign en_next     = wr_ctrl ? bus.writedata[0] : en_reg;
  assign blink_next  = wr_ctrl ? bus.writedata[1] : blink_reg;
  assign scroll_next = wr_ctrl ? bus.writedata[2] : scroll_reg;

  assign tick     = en_reg && (cnt_reg == CNT_MAX);
  assign cnt_next = (!en_reg || tick) ? '0 : cnt_reg + 1'b1;

  assign phase_next  = (en_next && blink_next) ? (phase_reg ^ tick) : 1'b0;
  assign offset_next = !(en_next && scroll_next) ? 3'd0 :
                       !tick                     ? offset_reg :
                       (offset_reg == 3'd5)      ? 3'd0 : offset_reg + 3'd1;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = {16'd0, digits_lo_reg};
      3'd1:    rd_mux = {24'd0, digits_hi_reg};
      3'd2:    rd_mux = {18'd0, blank_reg, 5'd0, scroll_reg, blink_reg, en_reg};
      3'd3:    rd_mux = {25'd0, offset_reg, 3'd0, phase_reg};
      default: rd_mux = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig_lo
      assign digit[gi] = digits_lo_reg[4*gi +: 4];
    end
    for (gi = 0; gi < 2; gi++) begin : g_dig_hi
      assign digit[gi+4] = digits_hi_reg[4*gi +: 4];
    end
    // Position gi shows digit (gi + offset) mod 6; blanking is by position.
    for (gi = 0; gi < 6; gi++) begin : g_pos
      logic [3:0] sum;
      logic [2:0] idx;
      assign sum = 4'(gi) + {1'b0, offset_reg};
      assign idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      assign hex_next[gi] = (!en_reg || (blink_reg && phase_reg) || blank_reg[gi])
                            ? 7'h7F : seg7(digit[idx]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_lo_reg <= '0;
      digits_hi_reg <= '0;
      en_reg        <= 1'b0;
      blink_reg     <= 1'b0;
      scroll_reg    <= 1'b0;
      blank_reg     <= '0;
      cnt_reg       <= '0;
      phase_reg     <= 1'b0;
      offset_reg    <= '0;
      readdata_reg  <= '0;
      for (int i = 0; i < 6; i++) hex_reg[i] <= 7'h7F;
    end else begin
      if (bus.write) begin
        case (bus.address)
          3'd0: digits_lo_reg <= bus.writedata[15:0];
          3'd1: digits_hi_reg <= bus.writedata[7:0];
          3'd2: begin
            en_reg     <= bus.writedata[0];
            blink_reg  <= bus.writedata[1];
            scroll_reg <= bus.writedata[2];
            blank_reg  <= bus.writedata[13:8];
          end
          default: ;
        endcase
      end
      if (bus.read) readdata_reg <= rd_mux;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      offset_reg <= offset_next;
      for (int i = 0; i < 6; i++) hex_reg[i] <= hex_next[i];
    end
  end

  assign bus.readdata = readdata_reg;
  assign hex0 = hex_reg[0];
  assign hex1 = hex_reg[1];
  assign hex2 = hex_reg[2];
  assign hex3 = hex_reg[3];
  assign hex4 = hex_reg[4];
  assign hex5 = hex_reg[5];
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (TICK_DIV=4): stimulus queues the
// expected readdata / hex vectors, a monitor pops and compares them.
module tb_hex_display_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_vec;
  logic hex_chk = 1'b0;
  logic hex_now = 1'b0;
  logic rd_seen;
  logic [31:0] last_rd = '0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_hex;
    string       name;
    logic [41:0] exp;
  } exp_t;
  exp_t sb_q[$];

  localparam logic [41:0] ALL_OFF = {6{7'h7F}};
  localparam logic [41:0] OFS0    = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [41:0] OFS1    = {7'h40, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [41:0] OFS3    = {7'h24, 7'h79, 7'h40, 7'h12, 7'h19, 7'h30};
  localparam logic [41:0] BLANK05 = {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F};

  hex_display_ctrl_if bus();

  hex_display_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;
  assign hex_vec = {hex5, hex4, hex3, hex2, hex1, hex0};

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rd_seen <= 1'b0;
    else          rd_seen <= bus.read;

  task automatic pop_check(input bit is_hex, input logic [41:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: output with nothing queued, actual %h", is_hex ? "hex" : "readdata", act);
      return;
    end
    e = sb_q.pop_front();
    if (e.is_hex != is_hex || act !== e.exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", e.name, act, e.exp);
    end else begin
      $display("ok   %s: %h", e.name, act);
    end
  endtask

  // Monitor: readdata one cycle after a read, hex on request, readdata hold otherwise.
  initial forever begin
    @(negedge clk or posedge hex_now);
    if (hex_now) begin
      pop_check(1'b1, hex_vec);
    end else if (!reset_n) begin
      last_rd = '0;
    end else begin
      if (rd_seen) begin
        pop_check(1'b0, {10'd0, bus.readdata});
        last_rd = bus.readdata;
      end else begin
        checks++;
        if (bus.readdata !== last_rd) begin
          errors++;
          $display("FAIL readdata_hold: actual %h required %h", bus.readdata, last_rd);
        end
      end
      if (hex_chk) pop_check(1'b1, hex_vec);
    end
  end

  task automatic push(input bit is_hex, input string name, input logic [41:0] exp);
    exp_t e;
    e.is_hex = is_hex;
    e.name   = name;
    e.exp    = exp;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    cyc();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    push(1'b0, name, {10'd0, exp});
    bus.address = a; bus.read = 1'b1;
    cyc();
    bus.read = 1'b0;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    push(1'b0, name, {10'd0, exp});
    bus.address = a; bus.writedata = d; bus.read = 1'b1; bus.write = 1'b1;
    cyc();
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic chk_hex(input logic [41:0] exp, input string name);
    push(1'b1, name, exp);
    hex_chk = 1'b1;
    @(negedge clk);
    #1 hex_chk = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    chk_hex(ALL_OFF, "reset_hex");
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_rd%0d", a));

    // Static display, ignored bits/addresses, read-during-write
    wr(3'd0, 32'h0000_3210);
    wr(3'd1, 32'hFFFF_FF54);
    wr(3'd2, 32'h0000_0001);
    cyc();
    chk_hex(OFS0, "static_hex");
    rd(3'd3, 32'd0, "static_status");
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd6, 32'h0000_1234);
    rd(3'd3, 32'd0, "status_ro");
    rd(3'd0, 32'h0000_3210, "digits_lo");
    rd(3'd1, 32'h0000_0054, "digits_hi");
    rd(3'd2, 32'h0000_0001, "ctrl_after_addr6");
    rd(3'd6, 32'd0, "addr6_zero");
    rdwr(3'd0, 32'h0000_ABCD, 32'h0000_3210, "rdwr_prewrite");
    rd(3'd0, 32'h0000_ABCD, "rdwr_postwrite");
    wr(3'd0, 32'h0000_3210);

    // Scroll: counter restarted by EN=0 then CTRL=5
    wr(3'd2, 32'h0);
    wr(3'd2, 32'h5);
    repeat (3) cyc();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      rd(3'd3, 32'((k % 6) << 4), $sformatf("scroll_ofs%0d", k % 6));
      if (k == 1) chk_hex(OFS1, "scroll_hex_ofs1");
      repeat (2) cyc();
    end
    repeat (10) cyc();
    rd(3'd3, 32'h30, "scroll_ofs3");
    chk_hex(OFS3, "scroll_hex_ofs3");

    // Asynchronous reset mid-scroll
    reset_n = 1'b0;
    #1 push(1'b1, "async_reset_hex", ALL_OFF);
    hex_now = 1'b1;
    #1 hex_now = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rd(3'd3, 32'd0, "post_reset_status");
    rd(3'd0, 32'd0, "post_reset_digits");
    chk_hex(ALL_OFF, "post_reset_hex");

    // Blink, then a CTRL write in the tick cycle cancels the blank frame
    wr(3'd0, 32'h0000_3210);
    wr(3'd1, 32'h0000_0054);
    wr(3'd2, 32'h3);
    cyc();
    chk_hex(OFS0, "blink_on_frame");
    repeat (4) cyc();
    rd(3'd3, 32'h1, "blink_phase1");
    chk_hex(ALL_OFF, "blink_off_frame");
    repeat (3) cyc();
    chk_hex(OFS0, "blink_on_frame2");
    repeat (2) cyc();
    wr(3'd2, 32'h1);
    rd(3'd3, 32'd0, "tick_write_phase0");
    chk_hex(OFS0, "tick_write_no_blank");
    repeat (4) cyc();
    chk_hex(OFS0, "blink_stopped");

    // Position blanking, then EN=0 freezes everything
    wr(3'd2, 32'h2101);
    cyc();
    chk_hex(BLANK05, "blank_mask");
    rd(3'd2, 32'h2101, "ctrl_blank_rd");
    wr(3'd2, 32'h0);
    cyc();
    chk_hex(ALL_OFF, "disabled_hex");
    rd(3'd3, 32'd0, "disabled_status");
    repeat (7) cyc();
    wr(3'd2, 32'h5);
    repeat (2) cyc();
    rd(3'd3, 32'd0, "restart_ofs0_a");
    rd(3'd3, 32'd0, "restart_ofs0_b");
    rd(3'd3, 32'h10, "restart_ofs1");

    repeat (3) cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
